// File: rtl/viu_pkg.sv
// Shared VIU types: default table geometry, route entry layout and flush FSM encoding.
package viu_pkg;

    localparam int unsigned VIU_N_PORTS    = 4;
    localparam int unsigned VIU_N_DESTS    = 4;
    localparam int unsigned VIU_UL_ID_BITS = 4;

    typedef struct packed {
        logic                      valid;
        logic [VIU_UL_ID_BITS-1:0] ul_id;
        logic [VIU_N_DESTS-1:0]    dest_mask;
    } viu_route_entry_t;

    typedef logic viu_flush_state_t;
    localparam viu_flush_state_t ST_IDLE  = 1'b0;
    localparam viu_flush_state_t ST_FLUSH = 1'b1;

endpackage

// File: rtl/viu_route_table_if.sv
// Host config and send-path lookup/verdict bus of the VIU route table.
interface viu_route_table_if
    import viu_pkg::*;
#(
    parameter int unsigned N_PORTS    = VIU_N_PORTS,
    parameter int unsigned N_DESTS    = VIU_N_DESTS,
    parameter int unsigned UL_ID_BITS = VIU_UL_ID_BITS
);
    localparam int unsigned PORT_BITS  = $clog2(N_PORTS);
    localparam int unsigned DEST_BITS  = (N_DESTS > 1) ? $clog2(N_DESTS) : 1;
    localparam int unsigned ENTRY_BITS = 1 + UL_ID_BITS + N_DESTS;

    logic                  cfg_valid;
    logic [PORT_BITS-1:0]  cfg_port;
    logic                  cfg_revoke;
    logic [UL_ID_BITS-1:0] cfg_ul_id;
    logic [N_DESTS-1:0]    cfg_dest_mask;
    logic                  cfg_flush;

    logic                  req_valid;
    logic                  req_ready;
    logic [PORT_BITS-1:0]  req_port;
    logic [UL_ID_BITS-1:0] req_ul_id;
    logic [DEST_BITS-1:0]  req_dest;

    logic                  resp_valid;
    logic                  resp_ready;
    logic                  resp_allow;
    logic [ENTRY_BITS-1:0] resp_entry;

    modport master (
        output cfg_valid, cfg_port, cfg_revoke, cfg_ul_id, cfg_dest_mask, cfg_flush,
        output req_valid, req_port, req_ul_id, req_dest, resp_ready,
        input  req_ready, resp_valid, resp_allow, resp_entry
    );

    modport slave (
        input  cfg_valid, cfg_port, cfg_revoke, cfg_ul_id, cfg_dest_mask, cfg_flush,
        input  req_valid, req_port, req_ul_id, req_dest, resp_ready,
        output req_ready, resp_valid, resp_allow, resp_entry
    );

endinterface

// File: rtl/viu_sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module viu_sat_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            count_q <= '0;
        end else if (inc && !(&count_q)) begin
            count_q <= count_q + WIDTH'(1);
        end
    end

    assign count = count_q;

endmodule

// File: rtl/viu_route_table.sv
// VIU send-path routing-capability table: per-port {valid, ul_id, dest_mask}, 1-cycle lookups,
// revoke, sequential flush and saturating deny counter. VIU_ROUTE_AUDIT_EN adds a denial audit port.
module viu_route_table
    import viu_pkg::*;
#(
    parameter int unsigned N_PORTS       = VIU_N_PORTS,
    parameter int unsigned N_DESTS       = VIU_N_DESTS,
    parameter int unsigned UL_ID_BITS    = VIU_UL_ID_BITS,
    parameter int unsigned DENY_CNT_BITS = 16
) (
    input  logic                     aclk,
    input  logic                     aresetn,
    viu_route_table_if.slave         bus,
    output logic                     flush_busy,
    output logic [DENY_CNT_BITS-1:0] deny_cnt
`ifdef VIU_ROUTE_AUDIT_EN
    ,
    output logic                     audit_valid,
    output logic [$clog2(N_PORTS)-1:0] audit_port,
    output logic [UL_ID_BITS-1:0]    audit_ul_id,
    output logic [((N_DESTS > 1) ? $clog2(N_DESTS) : 1)-1:0] audit_dest
`endif
);

    localparam int unsigned PORT_BITS = $clog2(N_PORTS);
    localparam logic [PORT_BITS-1:0] LAST_IDX = PORT_BITS'(N_PORTS - 1);

    typedef struct packed {
        logic                  valid;
        logic [UL_ID_BITS-1:0] ul_id;
        logic [N_DESTS-1:0]    dest_mask;
    } entry_t;

    entry_t               entry_q [N_PORTS];
    viu_flush_state_t     state_q, state_d;
    logic [PORT_BITS-1:0] flush_idx_q, flush_idx_d;
    logic                 resp_valid_q, resp_allow_q;
    entry_t               resp_entry_q;

    entry_t rd_entry;
    logic   port_ok, dest_ok, allow, req_ready, accept;

    assign flush_busy = (state_q == ST_FLUSH);
    assign req_ready  = ~flush_busy & (~resp_valid_q | bus.resp_ready);
    assign accept     = bus.req_valid & req_ready;

    // Lookup reads the registered table, so a same-edge cfg write is seen only by later lookups.
    always_comb begin
        port_ok  = 32'(bus.req_port) < N_PORTS;
        dest_ok  = 32'(bus.req_dest) < N_DESTS;
        rd_entry = port_ok ? entry_q[bus.req_port] : '0;
        allow    = rd_entry.valid && (rd_entry.ul_id == bus.req_ul_id) && dest_ok &&
                   rd_entry.dest_mask[bus.req_dest];
    end

    always_comb begin
        state_d     = state_q;
        flush_idx_d = flush_idx_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.cfg_flush) begin
                    state_d     = ST_FLUSH;
                    flush_idx_d = '0;
                end
            end
            default: begin
                flush_idx_d = flush_idx_q + PORT_BITS'(1);
                if (flush_idx_q == LAST_IDX) state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q     <= ST_IDLE;
            flush_idx_q <= '0;
        end else begin
            state_q     <= state_d;
            flush_idx_q <= flush_idx_d;
        end
    end

    // A flush step on the same index overrides a concurrent cfg write.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            entry_q <= '{default: '0};
        end else begin
            if (bus.cfg_valid && (32'(bus.cfg_port) < N_PORTS)) begin
                if (bus.cfg_revoke) entry_q[bus.cfg_port].valid <= 1'b0;
                else entry_q[bus.cfg_port] <= {1'b1, bus.cfg_ul_id, bus.cfg_dest_mask};
            end
            if (state_q == ST_FLUSH) entry_q[flush_idx_q].valid <= 1'b0;
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            resp_valid_q <= 1'b0;
            resp_allow_q <= 1'b0;
            resp_entry_q <= '0;
        end else if (accept) begin
            resp_valid_q <= 1'b1;
            resp_allow_q <= allow;
            resp_entry_q <= rd_entry;
        end else if (bus.resp_ready) begin
            resp_valid_q <= 1'b0;
        end
    end

    assign bus.req_ready  = req_ready;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_allow = resp_allow_q;
    assign bus.resp_entry = resp_entry_q;

    viu_sat_counter #(
        .WIDTH (DENY_CNT_BITS)
    ) u_deny_cnt (
        .aclk    (aclk),
        .aresetn (aresetn),
        .inc     (accept & ~allow),
        .count   (deny_cnt)
    );

`ifdef VIU_ROUTE_AUDIT_EN
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            audit_valid <= 1'b0;
            audit_port  <= '0;
            audit_ul_id <= '0;
            audit_dest  <= '0;
        end else begin
            audit_valid <= accept & ~allow;
            if (accept && !allow) begin
                audit_port  <= bus.req_port;
                audit_ul_id <= bus.req_ul_id;
                audit_dest  <= bus.req_dest;
            end
        end
    end
`endif

endmodule

// File: doc/viu_route_table.md
Name: viu_route_table

Overview:
- Parametrised routing-capability table for the VLAN Isolation Unit (VIU) send path.
- Host programs one capability entry per user-logic port: valid bit, owning sender UL id, permitted-destination mask.
- Send path issues lookups (port, UL id, destination) over a valid/ready handshake and receives an allow/deny verdict plus the stored entry.
- Supports revoke, bulk flush and a saturating deny counter. Sits between host control registers and the VIU egress gate.

Parameters:
- N_PORTS, 4, number of user-logic ports / table entries (>=2).
- N_DESTS, 4, number of destinations; width of the permit mask.
- UL_ID_BITS, 4, width of the sender UL id.
- DENY_CNT_BITS, 16, width of the deny counter.
- Derived (not overridable): PORT_BITS = $clog2(N_PORTS); DEST_BITS = max(1, $clog2(N_DESTS)).

Ports:
- aclk  in  1  clock.
- aresetn  in  1  reset; synchronous, active-low.
- cfg_valid  in  1  config write strobe, single cycle, no backpressure.
- cfg_port  in  PORT_BITS  entry index to write.
- cfg_revoke  in  1  1 = clear the entry's valid bit; 0 = install the entry.
- cfg_ul_id  in  UL_ID_BITS  owning sender UL id.
- cfg_dest_mask  in  N_DESTS  permitted destinations.
- cfg_flush  in  1  pulse: invalidate all entries.
- flush_busy  out  1  flush in progress.
- req_valid / req_ready  in / out  1 / 1  lookup handshake.
- req_port  in  PORT_BITS  port to look up.
- req_ul_id  in  UL_ID_BITS  requesting UL id.
- req_dest  in  DEST_BITS  requested destination.
- resp_valid / resp_ready  out / in  1 / 1  verdict handshake.
- resp_allow  out  1  1 = send permitted.
- resp_entry  out  1+UL_ID_BITS+N_DESTS  stored entry {valid, ul_id, mask}.
- deny_cnt  out  DENY_CNT_BITS  saturating count of denied lookups.

Behaviour:
- Reset: all entries invalid (zero); resp_valid=0, resp_allow=0, resp_entry=0, deny_cnt=0, flush_busy=0, FSM=IDLE. Reset mid-flush or mid-response abandons the operation immediately.
- Config write: entry[cfg_port] is updated at the cfg_valid edge.
  - Install writes {1, cfg_ul_id, cfg_dest_mask}.
  - Revoke clears only the valid bit; ul_id and mask are retained.
- Lookup: 1-cycle latency. A request accepted at edge N (req_valid & req_ready) produces resp_valid at N+1.
  - req_ready = ~flush_busy & (~resp_valid | resp_ready).
  - resp_* are held stable while resp_valid & ~resp_ready.
- Allow rule: allow = entry.valid & (entry.ul_id == req_ul_id) & (req_dest < N_DESTS) & entry.mask[req_dest]. Otherwise deny.
- Collision: a lookup and a cfg write to the same port on the same edge read the OLD entry (read-before-write).
- Out-of-range req_port >= N_PORTS (non-power-of-2 N_PORTS): deny, resp_entry=0. An out-of-range cfg_port is ignored.
- deny_cnt increments by 1 on each accepted lookup that denies. It is counted at acceptance, and saturates at all-ones without wrapping.
- Flush FSM:
  - IDLE --cfg_flush--> FLUSH. In FLUSH, an index counter clears the valid bit of one entry per cycle, starting at 0.
  - FLUSH --index==N_PORTS-1--> IDLE.
  - flush_busy=1 throughout FLUSH, which lasts N_PORTS cycles.
  - cfg_flush while already in FLUSH is ignored.
  - cfg_valid during FLUSH is applied, but a later flush step may clear it. Host must wait for flush_busy=0 before reprogramming.
- A response already pending at flush start completes normally. No new request is accepted until IDLE.

Optional Feature:
- Macro VIU_ROUTE_AUDIT_EN.
  - Defined: adds outputs audit_valid (1), audit_port (PORT_BITS), audit_ul_id (UL_ID_BITS), audit_dest (DEST_BITS), registered and pulsed 1 cycle alongside the response of every denied lookup, with no backpressure.
  - Undefined: these ports and their logic are absent, and the rest of the behaviour is identical.

Decomposition:
- Shared package viu_pkg holds:
  - typedef viu_route_entry_t {valid, ul_id, dest_mask}, parametrised via localparams VIU_N_PORTS, VIU_N_DESTS, VIU_UL_ID_BITS;
  - typedef for FSM state {ST_IDLE, ST_FLUSH}.
- One natural sub-module, viu_sat_counter: parametrised saturating counter, reused for deny_cnt.

Test Plan:
- Install port 1 {ul 3, mask 4'b0101}; lookup (1, 3, dest 2) -> resp_allow=1 next cycle; lookup (1, 3, dest 1) -> allow=0, deny_cnt=1.
- Lookup (1, ul 5, dest 0) on the same entry -> deny on UL mismatch; revoke port 1, then lookup (1, 3, 2) -> deny, resp_entry.valid=0 with ul_id=3 retained.
- Same-edge install of port 2 {ul 7, mask 4'b1000} plus lookup (2, 7, 3) -> deny (old entry); repeat lookup -> allow.
- Hold resp_ready=0 for 5 cycles with req_valid=1 -> req_ready=0, resp_* stable; release -> exactly one response per accepted request, no loss or duplication.
- Program all 4 ports, pulse cfg_flush -> flush_busy high for exactly 4 cycles, req_ready=0; then all lookups deny.
- DENY_CNT_BITS=2, five denied lookups -> deny_cnt stays at 3. With VIU_ROUTE_AUDIT_EN, each denial pulses audit_valid with the matching port, UL id and dest.
